// File: rtl/npu_dma_ctrl_if.sv
// ---------------------------------------------------------------------------
// npu_dma_ctrl_if
// Word-granular request/grant memory bus between the NPU DMA controller
// (master) and the memory fabric (slave).
//   m_req_o    master->slave  request valid, held until m_gnt_i
//   m_we_o     master->slave  1=write, 0=read
//   m_addr_o   master->slave  byte address
//   m_wdata_o  master->slave  write data
//   m_gnt_i    slave->master  request accepted this cycle
//   m_rvalid_i slave->master  read data valid
//   m_rdata_i  slave->master  read data
// ---------------------------------------------------------------------------
interface npu_dma_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req_o;
  logic              m_we_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic              m_gnt_i;
  logic              m_rvalid_i;
  logic [DATA_W-1:0] m_rdata_i;

  modport master (
    output m_req_o, m_we_o, m_addr_o, m_wdata_o,
    input  m_gnt_i, m_rvalid_i, m_rdata_i
  );

  modport slave (
    input  m_req_o, m_we_o, m_addr_o, m_wdata_o,
    output m_gnt_i, m_rvalid_i, m_rdata_i
  );
endinterface

// File: rtl/npu_dma_ctrl.sv
// ---------------------------------------------------------------------------
// npu_dma_ctrl
// Single-channel DMA that copies len_i words from external memory into one of
// four on-chip NPU memories (IMEM/WMEM/BMEM/PARA), one read then one write per
// word over a request/grant bus.
//   clk, rst      clock, synchronous active-high reset
//   start_i       start request, only honoured in IDLE
//   src_base_i    external-memory source byte address
//   dst_sel_i     0=IMEM 1=WMEM 2=BMEM 3=PARA
//   len_i         transfer length in words
//   busy_o        high while not IDLE
//   done_o        one-cycle completion pulse
//   err_o         one-cycle error pulse, coincident with done_o
//   m             bus master port (see npu_dma_ctrl_if)
// All outputs are flops; they are loaded from next-state values so the bus
// sees a request in the cycle right after the state decision, with no
// combinational path from m_gnt_i/m_rvalid_i to the outputs.
// ---------------------------------------------------------------------------
module npu_dma_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     src_base_i,
  input  logic [1:0]            dst_sel_i,
  input  logic [15:0]           len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  npu_dma_ctrl_if.master        m
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_e;

  // Range checks run two bits wider than the address so src+4*len can never
  // wrap back into the legal window.
  localparam int CW = ((ADDR_W > 32) ? ADDR_W : 32) + 2;
  localparam logic [CW-1:0] EXT_LIMIT = CW'(34'h0_0200_4000);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_d;

  logic                req_q, we_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  // -------------------------------------------------------------------------
  // Destination decode and start-time legality checks
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] dst_base;
  logic [CW-1:0]     depth_ext, src_ext, bytes_ext, end_ext;
  logic              cfg_err;

  always_comb begin
    dst_base  = ADDR_W'(32'h1000_0000);
    depth_ext = CW'(32'h0000_C400);
    case (dst_sel_i)
      2'd0: begin dst_base = ADDR_W'(32'h1000_0000); depth_ext = CW'(32'h0000_C400); end
      2'd1: begin dst_base = ADDR_W'(32'h1000_C400); depth_ext = CW'(32'h0000_C400); end
      2'd2: begin dst_base = ADDR_W'(32'h1001_8800); depth_ext = CW'(32'h0000_0200); end
      default: begin dst_base = ADDR_W'(32'h1002_0A00); depth_ext = CW'(32'h0000_0200); end
    endcase
  end

  always_comb begin
    src_ext   = CW'(src_base_i);
    bytes_ext = CW'({len_i, 2'b00});
    end_ext   = src_ext + bytes_ext;
    cfg_err   = (src_base_i[1:0] != 2'b00) ||
                (end_ext > EXT_LIMIT) ||
                (bytes_ext > depth_ext);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d = src_base_i;
          dst_d = dst_base;
          cnt_d = len_i;
          if (cfg_err) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (len_i == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (m.m_gnt_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (m.m_rvalid_i) begin
          data_d  = m.m_rdata_i;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (m.m_gnt_i) begin
          src_d   = src_q + ADDR_W'(4);
          dst_d   = dst_q + ADDR_W'(4);
          cnt_d   = cnt_q - 16'd1;
          // cnt_q still holds the pre-decrement count here
          state_d = (cnt_q > 16'd1) ? S_RD_REQ : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address for the state being entered; zero when no request is up.
  always_comb begin
    addr_d = '0;
    if (state_d == S_RD_REQ)      addr_d = src_d;
    else if (state_d == S_WR_REQ) addr_d = dst_d;
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      req_q   <= (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
      we_q    <= (state_d == S_WR_REQ);
      addr_q  <= addr_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign m.m_req_o   = req_q;
  assign m.m_we_o    = we_q;
  assign m.m_addr_o  = addr_q;
  // The read-data latch only changes on rvalid in RD_WAIT, so it is already
  // stable for the whole WR_REQ phase.
  assign m.m_wdata_o = data_q;

endmodule

// File: tb/tb_npu_dma_ctrl.sv
module tb_npu_dma_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] src_base_i;
  logic [1:0]    dst_sel_i;
  logic [15:0]   len_i;
  logic          busy_o, done_o, err_o;

  npu_dma_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  npu_dma_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .src_base_i (src_base_i),
    .dst_sel_i  (dst_sel_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .m          (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- bus slave model (drives at negedge) ----------------
  int          gnt_dly = 0;
  int          rv_dly  = 1;
  int          wcnt    = 0;
  int          rv_cnt  = 0;
  logic [31:0] raddr   = '0;
  bit          waiting = 0;
  bit          req_seen = 0;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;
  logic [31:0] lg_addr[$];
  logic [31:0] lg_data[$];
  logic        lg_we[$];

  initial begin
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i  = '0;
  end

  always @(negedge clk) begin
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        bus.m_rvalid_i = 1'b1;
        bus.m_rdata_i  = mem_rd(raddr);
      end
    end
    if (bus.m_req_o) begin
      req_seen = 1;
      if (waiting) begin
        chk("hold_addr",  bus.m_addr_o,  h_addr);
        chk("hold_we",    bus.m_we_o,    h_we);
        chk("hold_wdata", bus.m_wdata_o, h_wdata);
      end
      h_addr = bus.m_addr_o; h_we = bus.m_we_o; h_wdata = bus.m_wdata_o;
      if (wcnt == gnt_dly) begin
        bus.m_gnt_i = 1'b1;
        wcnt = 0; waiting = 0;
        lg_addr.push_back(bus.m_addr_o);
        lg_we.push_back(bus.m_we_o);
        lg_data.push_back(bus.m_wdata_o);
        if (!bus.m_we_o) begin
          rv_cnt = rv_dly;
          raddr  = bus.m_addr_o;
        end
      end else begin
        wcnt++; waiting = 1;
      end
    end else begin
      wcnt = 0; waiting = 0;
    end
  end

  task automatic clr_log();
    lg_addr.delete(); lg_we.delete(); lg_data.delete();
    req_seen = 0;
  endtask

  task automatic check_log(input string tag, input logic [31:0] src, input logic [31:0] dst, input int n);
    chk({tag, "_ntx"}, lg_addr.size(), 2 * n);
    if (lg_addr.size() == 2 * n) begin
      for (int i = 0; i < n; i++) begin
        chk({tag, "_rd_addr"}, lg_addr[2*i],   src + 32'(4 * i));
        chk({tag, "_rd_we"},   lg_we[2*i],     1'b0);
        chk({tag, "_wr_addr"}, lg_addr[2*i+1], dst + 32'(4 * i));
        chk({tag, "_wr_we"},   lg_we[2*i+1],   1'b1);
        chk({tag, "_wr_data"}, lg_data[2*i+1], mem_rd(src + 32'(4 * i)));
      end
    end
  endtask

  // lat: cycles from start sample to done_o (1 = next cycle)
  task automatic run_xfer(input logic [31:0] src, input logic [1:0] sel, input logic [15:0] len,
                          input bit pulses, output int lat, output int ndone, output bit err_seen);
    @(negedge clk);
    src_base_i = src; dst_sel_i = sel; len_i = len; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    // scramble inputs: the transfer must run from its latched copy
    src_base_i = 32'hDEAD_BEE0; dst_sel_i = 2'd2; len_i = 16'd7;
    lat = 0; ndone = 0; err_seen = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) begin ndone++; lat = k; err_seen = err_o; end
      if (!busy_o) break;
      if (pulses) start_i = done_o ? 1'b1 : k[0];
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"},  busy_o,        1'b0);
    chk({tag, "_done"},  done_o,        1'b0);
    chk({tag, "_err"},   err_o,         1'b0);
    chk({tag, "_req"},   bus.m_req_o,   1'b0);
    chk({tag, "_we"},    bus.m_we_o,    1'b0);
    chk({tag, "_addr"},  bus.m_addr_o,  32'h0);
    chk({tag, "_wdata"}, bus.m_wdata_o, 32'h0);
  endtask

  int lat, nd;
  bit er;

  initial begin
    rst = 1'b1; start_i = 1'b0; src_base_i = '0; dst_sel_i = '0; len_i = '0;
    repeat (3) @(posedge clk);
    #1 chk_idle_outs("reset");
    @(negedge clk) rst = 1'b0;

    // 4-word IMEM copy, zero-wait bus
    gnt_dly = 0; rv_dly = 1; clr_log();
    run_xfer(32'h0000_4000, 2'd0, 16'd4, 0, lat, nd, er);
    chk("t1_lat", lat, 13); chk("t1_ndone", nd, 1); chk("t1_err", er, 0);
    check_log("t1", 32'h0000_4000, 32'h1000_0000, 4);

    // BMEM overflow: 0x81 words = 516 bytes
    clr_log();
    run_xfer(32'h0000_4000, 2'd2, 16'h0081, 0, lat, nd, er);
    chk("t2_lat", lat, 1); chk("t2_err", er, 1); chk("t2_noreq", req_seen, 0);

    // misaligned source
    clr_log();
    run_xfer(32'h0000_4002, 2'd2, 16'd1, 0, lat, nd, er);
    chk("t3_lat", lat, 1); chk("t3_err", er, 1); chk("t3_noreq", req_seen, 0);

    // source end 0x02004004 past external limit
    clr_log();
    run_xfer(32'h0200_3FFC, 2'd3, 16'd2, 0, lat, nd, er);
    chk("t4_err", er, 1); chk("t4_noreq", req_seen, 0);

    // source end wraps in 32 bits; must still be caught
    clr_log();
    run_xfer(32'hFFFF_FFFC, 2'd0, 16'd1, 0, lat, nd, er);
    chk("t5_err", er, 1); chk("t5_noreq", req_seen, 0);

    // source end exactly at limit 0x02004000 is legal
    clr_log();
    run_xfer(32'h0200_3FF8, 2'd3, 16'd2, 0, lat, nd, er);
    chk("t6_lat", lat, 7); chk("t6_err", er, 0);
    check_log("t6", 32'h0200_3FF8, 32'h1002_0A00, 2);

    // zero length
    clr_log();
    run_xfer(32'h0000_4000, 2'd3, 16'd0, 0, lat, nd, er);
    chk("t7_lat", lat, 1); chk("t7_ndone", nd, 1); chk("t7_err", er, 0);
    chk("t7_noreq", req_seen, 0);

    // slow bus: gnt after 3 waiting cycles, rvalid 5 after gnt (13 cycles/word)
    gnt_dly = 3; rv_dly = 5; clr_log();
    run_xfer(32'h0000_8000, 2'd1, 16'd2, 0, lat, nd, er);
    chk("t8_lat", lat, 27); chk("t8_ndone", nd, 1); chk("t8_err", er, 0);
    check_log("t8", 32'h0000_8000, 32'h1000_C400, 2);

    // start pulses during a 3-word transfer, including the DONE cycle
    gnt_dly = 0; rv_dly = 1; clr_log();
    run_xfer(32'h0000_0100, 2'd0, 16'd3, 1, lat, nd, er);
    chk("t9_lat", lat, 10); chk("t9_ndone", nd, 1);
    check_log("t9", 32'h0000_0100, 32'h1000_0000, 3);
    repeat (3) @(negedge clk);
    chk("t9_no_restart", busy_o, 0);

    // BMEM exactly full: 0x80 words = 0x200 bytes
    clr_log();
    run_xfer(32'h0000_1000, 2'd2, 16'h0080, 0, lat, nd, er);
    chk("t10_lat", lat, 385); chk("t10_err", er, 0);
    check_log("t10", 32'h0000_1000, 32'h1001_8800, 128);

    // reset during RD_WAIT of word 2 of 8, read data returns late
    gnt_dly = 0; rv_dly = 4; clr_log();
    @(negedge clk);
    src_base_i = 32'h0000_0300; dst_sel_i = 2'd0; len_i = 16'd8; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (lg_addr.size() >= 3) break;
    end
    chk("t11_reach", lg_addr.size(), 3);
    @(negedge clk);
    chk("t11_busy_rdwait", busy_o, 1); chk("t11_req_rdwait", bus.m_req_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outs("t11_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t11_late_busy", busy_o, 0); chk("t11_late_req", bus.m_req_o, 0);
    chk("t11_late_wdata", bus.m_wdata_o, 32'h0);
    rv_dly = 1; clr_log();
    run_xfer(32'h0000_0400, 2'd1, 16'd2, 0, lat, nd, er);
    chk("t11_lat", lat, 7); chk("t11_ndone", nd, 1); chk("t11_err", er, 0);
    check_log("t11", 32'h0000_0400, 32'h1000_C400, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_dma_ctrl.md
NPU_DMA_CTRL -- requirements
Module: npu_dma_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, bus address width.
REQ-002 SHALL provide parameter DATA_W, default 32, bus data width (one word = 4 bytes).
REQ-003 SHALL provide clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide start_i  input  1  start request, sampled only in IDLE.
REQ-006 SHALL provide src_base_i  input  ADDR_W  Ext. Mem source byte address.
REQ-007 SHALL provide dst_sel_i  input  2  target: 0=IMEM, 1=WMEM, 2=BMEM, 3=PARA.
REQ-008 SHALL provide len_i  input  16  transfer length in words.
REQ-009 SHALL provide busy_o  output  1  high while not IDLE.
REQ-010 SHALL provide done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL provide err_o  output  1  one-cycle error pulse, coincident with done_o.
REQ-012 SHALL provide m_req_o  output  1  bus request.
REQ-013 SHALL provide m_we_o  output  1  1=write, 0=read.
REQ-014 SHALL provide m_addr_o  output  ADDR_W  bus byte address.
REQ-015 SHALL provide m_wdata_o  output  DATA_W  write data.
REQ-016 SHALL provide m_gnt_i  input  1  request accepted this cycle.
REQ-017 SHALL provide m_rvalid_i / m_rdata_i  input  1 / DATA_W  read data return.

Function
REQ-018 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
REQ-019 Destination bases SHALL be: IMEM 0x10000000 (depth 0xC400), WMEM 0x1000C400 (0xC400), BMEM 0x10018800 (0x200), PARA 0x10020A00 (0x200).
REQ-020 On start_i in IDLE, SHALL latch src_base_i, dst_sel_i, len_i; later input changes ignored.
REQ-021 Error SHALL be flagged if src_base_i[1:0]!=0, or src_base_i+4*len_i > 0x02004000, or 4*len_i > selected depth; checks in >=34-bit arithmetic, no wrap.
REQ-022 On error or len_i==0, SHALL go IDLE->DONE with no bus request; err_o=1 only for error.
REQ-023 Otherwise IDLE->RD_REQ; RD_REQ: m_req_o=1, m_we_o=0, m_addr_o=src pointer; on m_gnt_i -> RD_WAIT.
REQ-024 RD_WAIT: m_req_o=0; on m_rvalid_i latch m_rdata_i, -> WR_REQ; m_rvalid_i SHALL be ignored in every other state.
REQ-025 WR_REQ: m_req_o=1, m_we_o=1, m_addr_o=dst pointer, m_wdata_o=latched word; on m_gnt_i, both pointers +4, remaining count -1; -> RD_REQ if remaining >0, else DONE.
REQ-026 m_addr_o, m_we_o, m_wdata_o SHALL stay stable while m_req_o=1 and m_gnt_i=0.
REQ-027 DONE SHALL last exactly one cycle with done_o=1, then -> IDLE.
REQ-028 With zero-wait bus (gnt same cycle, rvalid next cycle), start sampled in cycle t SHALL give done_o in cycle t+3N+1; error/len0 in cycle t+1.
REQ-029 start_i while busy_o=1 SHALL be ignored; start_i high in the DONE cycle SHALL be ignored.
REQ-030 Outputs SHALL be registered; no combinational path from m_gnt_i/m_rvalid_i to m_req_o.

Reset
REQ-031 rst high at a clock edge SHALL force IDLE from any state, including mid-transfer, outstanding read dropped.
REQ-032 Reset values: busy_o=0, done_o=0, err_o=0, m_req_o=0, m_we_o=0, m_addr_o=0, m_wdata_o=0, pointers/count/data latch =0.

Verification
REQ-033 src=0x00004000, sel=0, len=4, zero-wait bus -> reads 0x4000..0x400C, writes 0x10000000..0x1000000C in order, data matched, done_o at t+13, err_o=0.
REQ-034 sel=2, len=0x81 (516 B > 0x200) -> no m_req_o, done_o and err_o at t+1; same with src=0x00004002 (misaligned).
REQ-035 sel=1, len=2, m_gnt_i delayed 3 cycles and rvalid 5 cycles after gnt -> address/data held stable while waiting, writes to 0x1000C400/0x1000C404, done_o once.
REQ-036 len=0, sel=3 -> done_o at t+1, err_o=0, no bus traffic; start_i pulses during a 3-word transfer -> ignored, single done_o.
REQ-037 rst asserted in RD_WAIT of word 2 of 8 -> next cycle all outputs at reset values; late m_rvalid_i ignored; new start runs cleanly from word 0.
